// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_ctrl_pkg
// Brief    : Shared types and constants for the stack-datapath controller:
//            FSM states, opcodes, ALU selects, trap codes, control bundle.
// Revision : 1.0 - initial release
// ============================================================================
package stack_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_IR,
    S_DECODE,
    S_POP_A,
    S_POP_B,
    S_POP_U,
    S_EXEC,
    S_PUSH_R,
    S_MEM_RD,
    S_MEM_LATCH,
    S_PUSH_M,
    S_ST_POP,
    S_MEM_WR,
    S_JZ_POP,
    S_JZ_TEST,
    S_JUMP,
    S_DUP_RD,
    S_DUP_EX,
    S_HALT,
    S_TRAP
  } state_t;

  localparam logic [3:0] c_op_add  = 4'd0;
  localparam logic [3:0] c_op_sub  = 4'd1;
  localparam logic [3:0] c_op_and  = 4'd2;
  localparam logic [3:0] c_op_not  = 4'd3;
  localparam logic [3:0] c_op_push = 4'd4;
  localparam logic [3:0] c_op_pop  = 4'd5;
  localparam logic [3:0] c_op_jmp  = 4'd6;
  localparam logic [3:0] c_op_jz   = 4'd7;
  localparam logic [3:0] c_op_dup  = 4'd8;
  localparam logic [3:0] c_op_halt = 4'd15;

  localparam logic [2:0] c_alu_add  = 3'd0;
  localparam logic [2:0] c_alu_sub  = 3'd1;
  localparam logic [2:0] c_alu_and  = 3'd2;
  localparam logic [2:0] c_alu_not  = 3'd3;
  localparam logic [2:0] c_alu_pass = 3'd4;

  localparam logic [1:0] c_trap_none    = 2'd0;
  localparam logic [1:0] c_trap_under   = 2'd1;
  localparam logic [1:0] c_trap_over    = 2'd2;
  localparam logic [1:0] c_trap_illegal = 2'd3;

  // One-bit control strobes, registered together as a single bundle
  typedef struct packed {
    logic pc_en;
    logic ins_en;
    logic data_en;
    logic a_en;
    logic b_en;
    logic result_en;
    logic jump_sel;
    logic data_adr_sel;
    logic mem_data_sel;
    logic pc_plus;
    logic we;
    logic re;
    logic push;
    logic pop;
    logic tos;
    logic halted;
    logic trap;
  } ctrl_t;

  // Minimum stack occupancy an opcode needs before it may execute
  function automatic logic [1:0] needs_pops(input logic [3:0] op);
    case (op)
      c_op_add, c_op_sub, c_op_and:        needs_pops = 2'd2;
      c_op_not, c_op_pop, c_op_jz, c_op_dup: needs_pops = 2'd1;
      default:                             needs_pops = 2'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    is_legal = (op <= c_op_dup) || (op == c_op_halt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_occupancy.sv
`default_nettype none
// ============================================================================
// Module   : stack_occupancy
// Brief    : Up/down counter tracking the number of live stack entries.
// Revision : 1.0 - initial release
// ============================================================================
module stack_occupancy #(
  parameter int STACK_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_push,
  input  logic                               i_pop,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_count
);

  localparam int c_w = $clog2(STACK_DEPTH + 1);

  logic [c_w-1:0] r_count;

  // Count pushes up and pops down; the controller never asserts both at once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_push && !i_pop) begin
      r_count <= r_count + c_w'(1);
    end else if (i_pop && !i_push) begin
      r_count <= r_count - c_w'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/stack_controller_v2.sv
`default_nettype none
// ============================================================================
// Module   : stack_controller_v2
// Brief    : Multi-cycle Moore control FSM for the stack-based datapath, with
//            memory-ready handshake, occupancy tracking and sticky traps.
// Revision : 1.0 - initial release
// ============================================================================
module stack_controller_v2 #(
  parameter int OPCODE_W    = 4,
  parameter int STACK_DEPTH = 16,
  parameter int ALU_SEL_W   = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [OPCODE_W-1:0]               opcode,
  input  logic                              zero,
  input  logic                              mem_ready,
  output logic                              pcEn,
  output logic                              insEn,
  output logic                              dataEn,
  output logic                              Aen,
  output logic                              Ben,
  output logic                              resultEn,
  output logic                              jumpSel,
  output logic                              dataAdrSel,
  output logic                              memDataSel,
  output logic                              pcPlus,
  output logic                              WE,
  output logic                              RE,
  output logic                              push,
  output logic                              pop,
  output logic                              tos,
  output logic [ALU_SEL_W-1:0]              aluSignal,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  sp_count,
  output logic                              halted,
  output logic                              trap,
  output logic [1:0]                        trap_code
);
  import stack_ctrl_pkg::*;

  localparam int c_sp_w = $clog2(STACK_DEPTH + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  ctrl_t                 r_ctrl;
  ctrl_t                 w_ctrl_nxt;
  logic [ALU_SEL_W-1:0]  r_alu;
  logic [ALU_SEL_W-1:0]  w_alu_nxt;
  logic [1:0]            r_tcode;
  logic [1:0]            w_tcode_nxt;
  logic [3:0]            w_op;
  logic                  w_legal;
  logic [1:0]            w_need;
  logic [c_sp_w-1:0]     w_sp;

  // Opcodes wider than four bits are legal only when the upper bits are zero
  assign w_op    = opcode[3:0];
  assign w_legal = ((opcode >> 4) == '0) && is_legal(w_op);
  assign w_need  = needs_pops(w_op);

  // Next-state selection, including the occupancy checks made in DECODE
  always_comb begin
    w_state_nxt = r_state;
    w_tcode_nxt = r_tcode;
    case (r_state)
      S_IDLE:      w_state_nxt = S_FETCH;
      S_FETCH:     if (mem_ready) w_state_nxt = S_LOAD_IR;
      S_LOAD_IR:   w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (!w_legal) begin
          w_state_nxt = S_TRAP;
          w_tcode_nxt = c_trap_illegal;
        end else if (c_sp_w'(w_need) > w_sp) begin
          w_state_nxt = S_TRAP;
          w_tcode_nxt = c_trap_under;
        end else if ((w_op == c_op_push || w_op == c_op_dup) &&
                     (w_sp == c_sp_w'(STACK_DEPTH))) begin
          w_state_nxt = S_TRAP;
          w_tcode_nxt = c_trap_over;
        end else begin
          case (w_op)
            c_op_add, c_op_sub, c_op_and: w_state_nxt = S_POP_A;
            c_op_not:  w_state_nxt = S_POP_U;
            c_op_push: w_state_nxt = S_MEM_RD;
            c_op_pop:  w_state_nxt = S_ST_POP;
            c_op_jmp:  w_state_nxt = S_JUMP;
            c_op_jz:   w_state_nxt = S_JZ_POP;
            c_op_dup:  w_state_nxt = S_DUP_RD;
            c_op_halt: w_state_nxt = S_HALT;
            default: begin
              w_state_nxt = S_TRAP;
              w_tcode_nxt = c_trap_illegal;
            end
          endcase
        end
      end
      S_POP_A:     w_state_nxt = S_POP_B;
      S_POP_B:     w_state_nxt = S_EXEC;
      S_POP_U:     w_state_nxt = S_EXEC;
      S_EXEC:      w_state_nxt = S_PUSH_R;
      S_PUSH_R:    w_state_nxt = S_FETCH;
      S_MEM_RD:    if (mem_ready) w_state_nxt = S_MEM_LATCH;
      S_MEM_LATCH: w_state_nxt = S_PUSH_M;
      S_PUSH_M:    w_state_nxt = S_FETCH;
      S_ST_POP:    w_state_nxt = S_MEM_WR;
      S_MEM_WR:    if (mem_ready) w_state_nxt = S_FETCH;
      S_JZ_POP:    w_state_nxt = S_JZ_TEST;
      S_JZ_TEST:   w_state_nxt = zero ? S_JUMP : S_FETCH;
      S_JUMP:      w_state_nxt = S_FETCH;
      S_DUP_RD:    w_state_nxt = S_DUP_EX;
      S_DUP_EX:    w_state_nxt = S_PUSH_R;
      S_HALT:      w_state_nxt = S_HALT;
      S_TRAP:      w_state_nxt = S_TRAP;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode of the state being entered, so outputs can be registered
  always_comb begin
    w_ctrl_nxt = '0;
    w_alu_nxt  = '0;
    case (w_state_nxt)
      S_FETCH:     w_ctrl_nxt.re = 1'b1;
      S_LOAD_IR: begin
        w_ctrl_nxt.pc_en   = 1'b1;
        w_ctrl_nxt.pc_plus = 1'b1;
        w_ctrl_nxt.ins_en  = 1'b1;
      end
      S_POP_A: begin
        w_ctrl_nxt.a_en = 1'b1;
        w_ctrl_nxt.pop  = 1'b1;
      end
      S_POP_B: begin
        w_ctrl_nxt.b_en = 1'b1;
        w_ctrl_nxt.pop  = 1'b1;
        w_alu_nxt       = ALU_SEL_W'(w_op);
      end
      S_POP_U: begin
        w_ctrl_nxt.a_en = 1'b1;
        w_ctrl_nxt.pop  = 1'b1;
        w_alu_nxt       = ALU_SEL_W'(c_alu_not);
      end
      S_EXEC: begin
        w_ctrl_nxt.result_en = 1'b1;
        w_alu_nxt            = r_alu;
      end
      S_PUSH_R:    w_ctrl_nxt.push = 1'b1;
      S_MEM_RD: begin
        w_ctrl_nxt.data_adr_sel = 1'b1;
        w_ctrl_nxt.re           = 1'b1;
      end
      S_MEM_LATCH: w_ctrl_nxt.data_en = 1'b1;
      S_PUSH_M: begin
        w_ctrl_nxt.mem_data_sel = 1'b1;
        w_ctrl_nxt.push         = 1'b1;
      end
      S_ST_POP: begin
        w_ctrl_nxt.pop          = 1'b1;
        w_ctrl_nxt.a_en         = 1'b1;
        w_ctrl_nxt.data_adr_sel = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl_nxt.we           = 1'b1;
        w_ctrl_nxt.data_adr_sel = 1'b1;
      end
      S_JZ_POP: begin
        w_ctrl_nxt.pop  = 1'b1;
        w_ctrl_nxt.a_en = 1'b1;
      end
      S_JZ_TEST:   w_alu_nxt = ALU_SEL_W'(c_alu_pass);
      S_JUMP: begin
        w_ctrl_nxt.jump_sel = 1'b1;
        w_ctrl_nxt.pc_en    = 1'b1;
      end
      S_DUP_RD: begin
        w_ctrl_nxt.tos  = 1'b1;
        w_ctrl_nxt.a_en = 1'b1;
      end
      S_DUP_EX: begin
        w_ctrl_nxt.result_en = 1'b1;
        w_alu_nxt            = ALU_SEL_W'(c_alu_pass);
      end
      S_HALT:      w_ctrl_nxt.halted = 1'b1;
      S_TRAP:      w_ctrl_nxt.trap   = 1'b1;
      default:     w_ctrl_nxt = '0;
    endcase
  end

  // State and registered outputs; reset clears every strobe immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
      r_alu   <= '0;
      r_tcode <= c_trap_none;
    end else begin
      r_state <= w_state_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_alu   <= w_alu_nxt;
      r_tcode <= w_tcode_nxt;
    end
  end

  stack_occupancy #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_occupancy (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_ctrl.push),
    .i_pop   (r_ctrl.pop),
    .o_count (w_sp)
  );

  assign pcEn       = r_ctrl.pc_en;
  assign insEn      = r_ctrl.ins_en;
  assign dataEn     = r_ctrl.data_en;
  assign Aen        = r_ctrl.a_en;
  assign Ben        = r_ctrl.b_en;
  assign resultEn   = r_ctrl.result_en;
  assign jumpSel    = r_ctrl.jump_sel;
  assign dataAdrSel = r_ctrl.data_adr_sel;
  assign memDataSel = r_ctrl.mem_data_sel;
  assign pcPlus     = r_ctrl.pc_plus;
  assign WE         = r_ctrl.we;
  assign RE         = r_ctrl.re;
  assign push       = r_ctrl.push;
  assign pop        = r_ctrl.pop;
  assign tos        = r_ctrl.tos;
  assign halted     = r_ctrl.halted;
  assign trap       = r_ctrl.trap;
  assign aluSignal  = r_alu;
  assign sp_count   = w_sp;
  assign trap_code  = r_tcode;

endmodule
`default_nettype wire

// File: tb/tb_stack_controller_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_controller_v2
// Brief    : Scoreboard bench for stack_controller_v2 (STACK_DEPTH = 4).
//            Each queued record holds the inputs to drive in one cycle and
//            the outputs expected during that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_controller_v2;

  localparam logic [14:0] M_PCEN = 15'h4000;
  localparam logic [14:0] M_INS  = 15'h2000;
  localparam logic [14:0] M_DATA = 15'h1000;
  localparam logic [14:0] M_AEN  = 15'h0800;
  localparam logic [14:0] M_BEN  = 15'h0400;
  localparam logic [14:0] M_RES  = 15'h0200;
  localparam logic [14:0] M_JMP  = 15'h0100;
  localparam logic [14:0] M_DADR = 15'h0080;
  localparam logic [14:0] M_MDS  = 15'h0040;
  localparam logic [14:0] M_PCP  = 15'h0020;
  localparam logic [14:0] M_WE   = 15'h0010;
  localparam logic [14:0] M_RE   = 15'h0008;
  localparam logic [14:0] M_PUSH = 15'h0004;
  localparam logic [14:0] M_POP  = 15'h0002;
  localparam logic [14:0] M_TOS  = 15'h0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic pcEn, insEn, dataEn, Aen, Ben, resultEn, jumpSel, dataAdrSel;
  logic memDataSel, pcPlus, WE, RE, push, pop, tos, halted, trap;
  logic [2:0] aluSignal;
  logic [2:0] sp_count;
  logic [1:0] trap_code;

  always #5 clk = ~clk;

  stack_controller_v2 #(
    .OPCODE_W    (4),
    .STACK_DEPTH (4),
    .ALU_SEL_W   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcEn       (pcEn),
    .insEn      (insEn),
    .dataEn     (dataEn),
    .Aen        (Aen),
    .Ben        (Ben),
    .resultEn   (resultEn),
    .jumpSel    (jumpSel),
    .dataAdrSel (dataAdrSel),
    .memDataSel (memDataSel),
    .pcPlus     (pcPlus),
    .WE         (WE),
    .RE         (RE),
    .push       (push),
    .pop        (pop),
    .tos        (tos),
    .aluSignal  (aluSignal),
    .sp_count   (sp_count),
    .halted     (halted),
    .trap       (trap),
    .trap_code  (trap_code)
  );

  typedef struct {
    logic [14:0] s;
    logic [2:0]  alu;
    logic [2:0]  sp;
    logic [3:0]  flg;
    logic [3:0]  op;
    logic        mr;
    logic        z;
    logic        rs;
  } rec_t;

  rec_t       q[$];
  int         n_total = 0;
  int         n_bad   = 0;
  int         cyc     = 0;
  int         sp      = 0;
  logic [3:0] cur_op  = 4'd0;
  logic [3:0] cur_flg = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, want);
    end
  endtask

  // Queue one cycle of expectation; occupancy moves after a push/pop cycle
  task automatic e(input logic [14:0] s, input logic [2:0] alu = 3'd0,
                   input logic mr = 1'b1, input logic z = 1'b0, input logic rs = 1'b0);
    rec_t r;
    r.s = s; r.alu = alu; r.sp = 3'(sp); r.flg = cur_flg;
    r.op = cur_op; r.mr = mr; r.z = z; r.rs = rs;
    q.push_back(r);
    if ((s & M_PUSH) != 0) sp++;
    if ((s & M_POP) != 0) sp--;
  endtask

  // Assert rst in the last queued cycle plus n-1 more, then release
  task automatic hold_reset(input int n);
    rec_t t;
    if (q.size() > 0) begin
      t = q.pop_back();
      t.rs = 1'b1;
      q.push_back(t);
    end
    sp = 0;
    cur_flg = 4'd0;
    for (int i = 0; i < n - 1; i++) e(15'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    e(15'h0, 3'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ins_fetch(input logic [3:0] op, input int stall);
    cur_op = op;
    for (int i = 0; i < stall; i++) e(M_RE, 3'd0, 1'b0);
    e(M_RE);
    e(M_PCEN | M_PCP | M_INS);
    e(15'h0);
  endtask

  task automatic ins_push(input int stall);
    ins_fetch(4'd4, stall);
    e(M_DADR | M_RE);
    e(M_DATA);
    e(M_MDS | M_PUSH);
  endtask

  task automatic ins_alu(input logic [3:0] op, input logic full);
    ins_fetch(op, 0);
    e(M_AEN | M_POP);
    e(M_BEN | M_POP, op[2:0]);
    e(M_RES, op[2:0]);
    if (full) e(M_PUSH);
  endtask

  task automatic ins_jz(input logic z);
    ins_fetch(4'd7, 0);
    e(M_POP | M_AEN);
    e(15'h0, 3'd4, 1'b1, z);
    if (z) e(M_JMP | M_PCEN);
  endtask

  task automatic ins_stuck(input logic [3:0] op, input logic [3:0] flg, input int n);
    ins_fetch(op, 0);
    cur_flg = flg;
    for (int i = 0; i < n; i++) e(15'h0);
  endtask

  initial begin
    rec_t r;
    rst = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;

    hold_reset(2);
    ins_push(0);
    ins_push(0);
    ins_alu(4'd0, 1'b1);                 // ADD: 2 -> 1
    ins_push(4);                         // FETCH stalled 4 cycles
    ins_alu(4'd1, 1'b1);                 // SUB
    ins_fetch(4'd3, 0);                  // NOT
    e(M_AEN | M_POP, 3'd3);
    e(M_RES, 3'd3);
    e(M_PUSH);
    ins_fetch(4'd8, 0);                  // DUP: 1 -> 2
    e(M_TOS | M_AEN);
    e(M_RES, 3'd4);
    e(M_PUSH);
    ins_jz(1'b1);
    ins_jz(1'b0);
    ins_fetch(4'd6, 0);                  // JMP
    e(M_JMP | M_PCEN);
    ins_push(0);
    ins_fetch(4'd5, 0);                  // POP with one write wait
    e(M_POP | M_AEN | M_DADR);
    e(M_WE | M_DADR, 3'd0, 1'b0);
    e(M_WE | M_DADR);
    ins_push(0);
    ins_push(0);
    ins_alu(4'd0, 1'b0);                 // abort in EXEC
    hold_reset(3);
    ins_push(0);
    ins_stuck(4'd0, 4'b0101, 11);        // ADD underflow
    hold_reset(2);
    for (int i = 0; i < 4; i++) ins_push(0);
    ins_stuck(4'd4, 4'b0110, 4);         // PUSH overflow at depth 4
    hold_reset(2);
    ins_stuck(4'd9, 4'b0111, 3);         // illegal opcode
    hold_reset(2);
    ins_stuck(4'd3, 4'b0101, 3);         // NOT on empty stack
    hold_reset(2);
    ins_stuck(4'd15, 4'b1000, 6);        // HALT sticky
    hold_reset(2);
    e(M_RE);

    repeat (2) @(posedge clk);
    while (q.size() > 0) begin
      @(negedge clk);
      r = q.pop_front();
      chk("strobes", 32'({pcEn, insEn, dataEn, Aen, Ben, resultEn, jumpSel, dataAdrSel,
                          memDataSel, pcPlus, WE, RE, push, pop, tos}), 32'(r.s));
      chk("alu", 32'(aluSignal), 32'(r.alu));
      chk("sp_count", 32'(sp_count), 32'(r.sp));
      chk("flags", 32'({halted, trap, trap_code}), 32'(r.flg));
      opcode    = r.op;
      mem_ready = r.mr;
      zero      = r.z;
      rst       = r.rs;
      cyc++;
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_controller_v2.md
Name: stack_controller_v2

Overview:
Parametrised multi-cycle control FSM for the stack-based MIPS datapath. It drives PC, IR, A/B/result registers, memory and stack strobes as Moore outputs. Unlike the first-generation controller it has a memory-ready handshake, tracks stack occupancy with underflow/overflow traps, and adds DUP and HALT opcodes. Illegal opcodes trap instead of falling through.

Parameters:
OPCODE_W, 4, instruction opcode width (must be >= 4)
STACK_DEPTH, 16, number of stack entries (>= 2); sizes sp_count
ALU_SEL_W, 3, ALU select width (>= 3; code 4 = PASS A)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
opcode  in  OPCODE_W  opcode field of IR
zero  in  1  ALU zero flag (combinational on current ALU result)
mem_ready  in  1  memory completes the current RE/WE access this cycle
pcEn, insEn, dataEn, Aen, Ben, resultEn  out  1 each  register load enables
jumpSel, dataAdrSel, memDataSel, pcPlus  out  1 each  datapath mux selects
WE, RE, push, pop, tos  out  1 each  memory / stack strobes
aluSignal  out  ALU_SEL_W  0 ADD, 1 SUB, 2 AND, 3 NOT, 4 PASS A
sp_count  out  clog2(STACK_DEPTH+1)  current stack occupancy
halted  out  1  sticky; HALT executed
trap  out  1  sticky; fault detected
trap_code  out  2  0 none, 1 underflow, 2 overflow, 3 illegal opcode

Behaviour:
- Reset: while rst=1 every output is 0 and sp_count=0. On the first edge with rst=0, state becomes FETCH. Reset mid-instruction aborts it with no strobe residue.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 NOT, 4 PUSH(mem), 5 POP(store), 6 JMP, 7 JZ, 8 DUP, 15 HALT. All others are illegal.
- Outputs not listed for a state are 0. aluSignal defaults to 0.
- FETCH: RE=1. Stays in FETCH until mem_ready=1, then goes to LOAD_IR.
- LOAD_IR: pcEn=pcPlus=insEn=1. Next state is DECODE.
- DECODE: no strobes. Checks occupancy, first match wins:
  - illegal opcode -> TRAP, code 3
  - ADD/SUB/AND with sp_count<2 -> TRAP, code 1
  - NOT/POP/JZ/DUP with sp_count<1 -> TRAP, code 1
  - PUSH/DUP with sp_count==STACK_DEPTH -> TRAP, code 2
  - Otherwise: ADD/SUB/AND -> POP_A; NOT -> POP_U; PUSH -> MEM_RD; POP -> ST_POP; JMP -> JUMP; JZ -> JZ_POP; DUP -> DUP_RD; HALT -> HALT.
- POP_A: Aen=pop=1. Next is POP_B.
- POP_B: Ben=pop=1, aluSignal=opcode. Next is EXEC.
- POP_U: Aen=pop=1, aluSignal=3. Next is EXEC.
- EXEC: resultEn=1, with aluSignal held from the previous state (3 for NOT, otherwise opcode). Next is PUSH_R.
- PUSH_R: push=1. Next is FETCH.
- MEM_RD: dataAdrSel=RE=1. Waits for mem_ready=1, then goes to MEM_LATCH.
- MEM_LATCH: dataEn=1. Next is PUSH_M.
- PUSH_M: memDataSel=push=1. Next is FETCH.
- ST_POP: pop=Aen=dataAdrSel=1. Next is MEM_WR.
- MEM_WR: WE=dataAdrSel=1. Waits for mem_ready=1, then goes to FETCH.
- JZ_POP: pop=Aen=1. Next is JZ_TEST.
- JZ_TEST: aluSignal=4. If zero=1, next is JUMP; otherwise FETCH.
- JUMP: jumpSel=pcEn=1. Next is FETCH.
- DUP_RD: tos=Aen=1. Next is DUP_EX.
- DUP_EX: aluSignal=4, resultEn=1. Next is PUSH_R.
- HALT: halted=1. Absorbing until rst.
- TRAP: trap=1, trap_code held. Absorbing until rst. No strobes are issued, so no further PC or stack activity.
- sp_count: +1 in any cycle with push=1, -1 in any cycle with pop=1. push and pop are never asserted together. The DECODE checks guarantee sp_count never wraps.
- Latency, with memory ready immediately: ALU op 7 cycles; NOT 6; PUSH 6; POP 5; JMP 4; JZ 5 (not taken) or 6 (taken); DUP 6.

Decomposition:
- Package stack_ctrl_pkg holds:
  - state enum
  - opcode localparams
  - ALU select localparams
  - trap code localparams
  - function needs_pops(opcode)
- One natural sub-module: stack_occupancy, which holds the sp_count up/down counter with a synchronous clear. The FSM keeps the occupancy checks in DECODE.

Test Plan:
- rst held 3 cycles mid-EXEC, then released with mem_ready=1 -> all outputs 0 during rst; sp_count=0; RE=1 on the first cycle after release.
- PUSH, PUSH, ADD with mem_ready always 1 -> sp_count goes 1, 2, then 1. ADD takes 7 cycles, with aluSignal=0 in POP_B and EXEC and exactly one push pulse.
- FETCH with mem_ready low for 4 cycles -> RE held for 5 cycles; insEn pulses once, in the cycle after mem_ready=1.
- JZ with zero=1 in JZ_TEST -> jumpSel=pcEn=1 in the next cycle. Repeated with zero=0 -> returns to FETCH and no pcEn after LOAD_IR.
- ADD with sp_count=1 -> trap=1, trap_code=1, sp_count unchanged; no pop for 10 further cycles.
- STACK_DEPTH=4: five PUSHes -> fifth traps with code 2 and sp_count=4. Separately, opcode 9 -> trap_code=3; opcode 15 -> halted=1 sticky.
